// File: rtl/aurora_pkg.sv
// Shared constants, ordered-set type and K-code mapping for the Aurora transmit
// byte-striping stage.
package aurora_pkg;

   localparam int MAX_LINKS            = 4;
   localparam int MAX_LINKS_SIZE       = 2;
   localparam int AXI_DATA_SIZE        = 32;
   localparam int ENCODER_DATA_IN_SIZE = 8;

   typedef enum logic [2:0] {
      NONE,
      IDLE,
      CLOCK_COMP,
      CHANNEL_BOND,
      RESYNC
   } ordered_sets_e;

   localparam logic [ENCODER_DATA_IN_SIZE-1:0] K28_5 = 8'hBC;
   localparam logic [ENCODER_DATA_IN_SIZE-1:0] K28_7 = 8'hFC;
   localparam logic [ENCODER_DATA_IN_SIZE-1:0] K28_3 = 8'h7C;
   localparam logic [ENCODER_DATA_IN_SIZE-1:0] K28_0 = 8'h1C;

   typedef struct packed {
      logic                            ctrl;
      logic [ENCODER_DATA_IN_SIZE-1:0] code;
   } lane_char_t;

   // NONE has no K-code; callers substitute data for it.
   function automatic lane_char_t os_encode(input ordered_sets_e os);
      lane_char_t result;
      case (os)
         IDLE:         result = '{ctrl: 1'b1, code: K28_5};
         CLOCK_COMP:   result = '{ctrl: 1'b1, code: K28_7};
         CHANNEL_BOND: result = '{ctrl: 1'b1, code: K28_3};
         RESYNC:       result = '{ctrl: 1'b1, code: K28_0};
         default:      result = '{ctrl: 1'b0, code: '0};
      endcase
      return result;
   endfunction

   function automatic logic [MAX_LINKS_SIZE-1:0] lane_map(input logic [MAX_LINKS_SIZE-1:0] sel);
      if (int'(sel) >= MAX_LINKS) begin
         return '0;
      end
      return sel;
   endfunction

endpackage

// File: rtl/aurora_lane_controller_if.sv
// Lane-controller bundle: word/ordered-set inputs and per-lane character outputs.
interface aurora_lane_controller_if
   import aurora_pkg::*;
   ();

   logic                                              single_lane;
   logic [MAX_LINKS_SIZE-1:0]                         lane_select;
   ordered_sets_e                                     ordered_sets;
   logic [AXI_DATA_SIZE-1:0]                          data_in;
   logic [MAX_LINKS-1:0]                              ctrl_out;
   logic [MAX_LINKS-1:0][ENCODER_DATA_IN_SIZE-1:0]    data_out;

   modport master (
      output single_lane,
      output lane_select,
      output ordered_sets,
      output data_in,
      input  ctrl_out,
      input  data_out
   );

   modport slave (
      input  single_lane,
      input  lane_select,
      input  ordered_sets,
      input  data_in,
      output ctrl_out,
      output data_out
   );

endinterface

// File: rtl/aurora_lane_controller_serializer.sv
// Single-lane serialiser: sends one 32-bit word MSB byte first over four cycles,
// pausing (not dropping) the current byte whenever an ordered set is requested.
module lane_serializer
   import aurora_pkg::*;
   (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       single_lane,
   input  logic [MAX_LINKS_SIZE-1:0]  lane_select,
   input  ordered_sets_e              ordered_sets,
   input  logic [AXI_DATA_SIZE-1:0]   data_in,
   output logic                       active,
   output logic [MAX_LINKS_SIZE-1:0]  lane,
   output lane_char_t                 symbol
);

   logic [1:0]                  cnt_reg;
   logic [AXI_DATA_SIZE-1:0]    word_reg;
   logic [MAX_LINKS_SIZE-1:0]   lane_reg;
   logic                        mode_reg;

   logic                        at_boundary;
   logic [AXI_DATA_SIZE-1:0]    word_src;
   logic [AXI_DATA_SIZE-1:0]    word_shifted;

   // Mode and lane only follow the inputs between words; mid-word they come from the latches.
   always_comb begin
      at_boundary  = (cnt_reg == 2'd0);
      active       = at_boundary ? single_lane : mode_reg;
      lane         = at_boundary ? lane_map(lane_select) : lane_reg;
      word_src     = at_boundary ? data_in : word_reg;
      word_shifted = word_src << {cnt_reg, 3'b000};
      if (ordered_sets != NONE) begin
         symbol = os_encode(ordered_sets);
      end else begin
         symbol = '{ctrl: 1'b0,
                    code: word_shifted[AXI_DATA_SIZE-1 -: ENCODER_DATA_IN_SIZE]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg  <= 2'd0;
         word_reg <= '0;
         lane_reg <= '0;
         mode_reg <= 1'b0;
      end else begin
         if (at_boundary) begin
            mode_reg <= single_lane;
            lane_reg <= lane_map(lane_select);
         end
         if (active && ordered_sets == NONE) begin
            cnt_reg <= cnt_reg + 2'd1;
            if (at_boundary) begin
               word_reg <= data_in;
            end
         end
      end
   end

endmodule

// File: rtl/aurora_lane_controller.sv
// Aurora TX byte-striping stage: muxes all-lanes striping against the single-lane
// serialiser and registers one character plus K flag per lane.
module aurora_lane_controller
   import aurora_pkg::*;
   (
   input  logic                      clk,
   input  logic                      rst,
   aurora_lane_controller_if.slave   bus
);

   logic                                            ser_active;
   logic [MAX_LINKS_SIZE-1:0]                       ser_lane;
   lane_char_t                                      ser_symbol;
   lane_char_t                                      os_symbol;
   logic [MAX_LINKS-1:0]                            ctrl_next;
   logic [MAX_LINKS-1:0][ENCODER_DATA_IN_SIZE-1:0]  data_next;

   lane_serializer u_serializer (
      .clk          (clk),
      .rst          (rst),
      .single_lane  (bus.single_lane),
      .lane_select  (bus.lane_select),
      .ordered_sets (bus.ordered_sets),
      .data_in      (bus.data_in),
      .active       (ser_active),
      .lane         (ser_lane),
      .symbol       (ser_symbol)
   );

   assign os_symbol = os_encode(bus.ordered_sets);

   // Lane 0 carries the most significant byte when striping.
   generate
      for (genvar gi = 0; gi < MAX_LINKS; gi++) begin : g_lane
         logic selected;
         assign selected = (ser_lane == MAX_LINKS_SIZE'(gi));

         assign data_next[gi] =
            ser_active ? (selected ? ser_symbol.code : K28_5) :
            (bus.ordered_sets != NONE) ? os_symbol.code :
            bus.data_in[AXI_DATA_SIZE-1-ENCODER_DATA_IN_SIZE*gi -: ENCODER_DATA_IN_SIZE];

         assign ctrl_next[gi] =
            ser_active ? (selected ? ser_symbol.ctrl : 1'b1) :
            (bus.ordered_sets != NONE);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ctrl_out <= '1;
         bus.data_out <= {MAX_LINKS{K28_5}};
      end else begin
         bus.ctrl_out <= ctrl_next;
         bus.data_out <= data_next;
      end
   end

endmodule

// File: tb/tb_aurora_lane_controller.sv
// Directed self-checking bench for aurora_lane_controller.
module tb_aurora_lane_controller;
   import aurora_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   aurora_lane_controller_if bus ();

   aurora_lane_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Expected {ctrl_out, data_out} with one active lane and IDLE on the others.
   function automatic logic [35:0] one_lane(input int ln, input logic [7:0] ch, input logic k);
      logic [3:0]      c;
      logic [3:0][7:0] d;
      c = 4'hF;
      for (int i = 0; i < 4; i++) d[i] = 8'hBC;
      d[ln] = ch;
      c[ln] = k;
      return {c, d};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [35:0] exp;
      exp = 36'hF_BCBCBCBC;
      bus.single_lane  = 1'b0;
      bus.lane_select  = 2'd0;
      bus.ordered_sets = IDLE;
      bus.data_in      = 32'h0;
      #2 rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.ctrl_out, bus.data_out} !== exp) begin
         n_bad++;
         $display("FAIL reset_held: got %h want %h", {bus.ctrl_out, bus.data_out}, exp);
      end else $display("reset_held: %h", exp);
      rst = 1'b0;
      step();
      n_cmp++;
      if ({bus.ctrl_out, bus.data_out} !== exp) begin
         n_bad++;
         $display("FAIL reset_idle: got %h want %h", {bus.ctrl_out, bus.data_out}, exp);
      end else $display("reset_idle: %h", exp);
   endtask

   task automatic test_striping();
      logic [35:0] exp [4];
      logic [31:0] words [4];
      ordered_sets_e oss [4];
      words = '{32'h11223344, 32'hDEADBEEF, 32'h0, 32'h0};
      oss   = '{NONE, NONE, RESYNC, CHANNEL_BOND};
      exp   = '{36'h0_44332211, 36'h0_EFBEADDE, 36'hF_1C1C1C1C, 36'hF_7C7C7C7C};
      bus.single_lane = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.ordered_sets = oss[i];
         bus.data_in      = words[i];
         step();
         n_cmp++;
         if ({bus.ctrl_out, bus.data_out} !== exp[i]) begin
            n_bad++;
            $display("FAIL striping[%0d]: got %h want %h", i, {bus.ctrl_out, bus.data_out}, exp[i]);
         end else $display("striping[%0d]: %h", i, exp[i]);
      end
   endtask

   task automatic test_single_lane();
      logic [7:0] bytes [4];
      logic [35:0] exp;
      bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      bus.single_lane  = 1'b1;
      bus.lane_select  = 2'd2;
      bus.ordered_sets = NONE;
      bus.data_in      = 32'hA1B2C3D4;
      for (int i = 0; i < 4; i++) begin
         step();
         bus.data_in = 32'hFFFF_FFFF;
         exp = one_lane(2, bytes[i], 1'b0);
         n_cmp++;
         if ({bus.ctrl_out, bus.data_out} !== exp) begin
            n_bad++;
            $display("FAIL single_lane[%0d]: got %h want %h", i, {bus.ctrl_out, bus.data_out}, exp);
         end else $display("single_lane[%0d]: %h", i, exp);
      end
   endtask

   task automatic test_os_insert();
      logic [35:0] exp [5];
      exp = '{one_lane(2, 8'hA1, 1'b0), one_lane(2, 8'hB2, 1'b0), one_lane(2, 8'hFC, 1'b1),
              one_lane(2, 8'hC3, 1'b0), one_lane(2, 8'hD4, 1'b0)};
      bus.single_lane = 1'b1;
      bus.lane_select = 2'd2;
      bus.data_in     = 32'hA1B2C3D4;
      for (int i = 0; i < 5; i++) begin
         bus.ordered_sets = (i == 2) ? CLOCK_COMP : NONE;
         step();
         bus.data_in = 32'h0BAD_0BAD;
         n_cmp++;
         if ({bus.ctrl_out, bus.data_out} !== exp[i]) begin
            n_bad++;
            $display("FAIL os_insert[%0d]: got %h want %h", i, {bus.ctrl_out, bus.data_out}, exp[i]);
         end else $display("os_insert[%0d]: %h", i, exp[i]);
      end
      bus.ordered_sets = NONE;
   endtask

   task automatic test_lane_change();
      logic [35:0] exp [8];
      exp = '{one_lane(2, 8'h55, 1'b0), one_lane(2, 8'h66, 1'b0), one_lane(2, 8'h77, 1'b0),
              one_lane(2, 8'h88, 1'b0), one_lane(0, 8'h99, 1'b0), one_lane(0, 8'hAA, 1'b0),
              one_lane(0, 8'hBB, 1'b0), one_lane(0, 8'hCC, 1'b0)};
      bus.single_lane  = 1'b1;
      bus.lane_select  = 2'd2;
      bus.ordered_sets = NONE;
      bus.data_in      = 32'h55667788;
      for (int i = 0; i < 8; i++) begin
         step();
         bus.lane_select = 2'd0;
         bus.data_in     = (i == 3) ? 32'h99AABBCC : 32'h1357_9BDF;
         n_cmp++;
         if ({bus.ctrl_out, bus.data_out} !== exp[i]) begin
            n_bad++;
            $display("FAIL lane_change[%0d]: got %h want %h", i, {bus.ctrl_out, bus.data_out}, exp[i]);
         end else $display("lane_change[%0d]: %h", i, exp[i]);
      end
   endtask

   task automatic test_mode_change();
      logic [35:0] exp [5];
      exp = '{one_lane(0, 8'h01, 1'b0), one_lane(0, 8'h02, 1'b0), one_lane(0, 8'h03, 1'b0),
              one_lane(0, 8'h04, 1'b0), 36'h0_44332211};
      bus.single_lane  = 1'b1;
      bus.lane_select  = 2'd0;
      bus.ordered_sets = NONE;
      bus.data_in      = 32'h01020304;
      for (int i = 0; i < 5; i++) begin
         step();
         bus.single_lane = 1'b0;
         bus.data_in     = 32'h11223344;
         n_cmp++;
         if ({bus.ctrl_out, bus.data_out} !== exp[i]) begin
            n_bad++;
            $display("FAIL mode_change[%0d]: got %h want %h", i, {bus.ctrl_out, bus.data_out}, exp[i]);
         end else $display("mode_change[%0d]: %h", i, exp[i]);
      end
   endtask

   task automatic test_reset_midword();
      logic [35:0] exp;
      bus.single_lane  = 1'b1;
      bus.lane_select  = 2'd1;
      bus.ordered_sets = NONE;
      bus.data_in      = 32'h12345678;
      step();
      bus.data_in = 32'h0;
      exp = one_lane(1, 8'h12, 1'b0);
      n_cmp++;
      if ({bus.ctrl_out, bus.data_out} !== exp) begin
         n_bad++;
         $display("FAIL midword_b0: got %h want %h", {bus.ctrl_out, bus.data_out}, exp);
      end else $display("midword_b0: %h", exp);
      step();
      exp = one_lane(1, 8'h34, 1'b0);
      n_cmp++;
      if ({bus.ctrl_out, bus.data_out} !== exp) begin
         n_bad++;
         $display("FAIL midword_b1: got %h want %h", {bus.ctrl_out, bus.data_out}, exp);
      end else $display("midword_b1: %h", exp);
      #2 rst = 1'b1;
      #1;
      exp = 36'hF_BCBCBCBC;
      n_cmp++;
      if ({bus.ctrl_out, bus.data_out} !== exp) begin
         n_bad++;
         $display("FAIL midword_reset: got %h want %h", {bus.ctrl_out, bus.data_out}, exp);
      end else $display("midword_reset: %h", exp);
      @(negedge clk);
      rst = 1'b0;
      bus.data_in = 32'hCAFEF00D;
      step();
      bus.data_in = 32'h0;
      exp = one_lane(1, 8'hCA, 1'b0);
      n_cmp++;
      if ({bus.ctrl_out, bus.data_out} !== exp) begin
         n_bad++;
         $display("FAIL post_reset_b0: got %h want %h", {bus.ctrl_out, bus.data_out}, exp);
      end else $display("post_reset_b0: %h", exp);
      step();
      exp = one_lane(1, 8'hFE, 1'b0);
      n_cmp++;
      if ({bus.ctrl_out, bus.data_out} !== exp) begin
         n_bad++;
         $display("FAIL post_reset_b1: got %h want %h", {bus.ctrl_out, bus.data_out}, exp);
      end else $display("post_reset_b1: %h", exp);
   endtask

   initial begin
      test_reset();
      test_striping();
      test_single_lane();
      test_os_insert();
      test_lane_change();
      test_mode_change();
      test_reset_midword();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/aurora_lane_controller.md
# aurora_lane_controller

Byte-striping stage of the Aurora transmit path. Takes 32-bit user words, or ordered-set requests from the link state machine, and produces one 8-bit character plus a K/control flag per lane. These outputs feed the per-lane 8b/10b encoders. Supports all-lanes striping and a single-lane serialising mode on a selectable lane.

## Interface
Parameters (from `aurora_pkg`, not overridable per instance):
- `MAX_LINKS`, 4: number of lanes.
- `MAX_LINKS_SIZE`, 2: width of a lane index.
- `AXI_DATA_SIZE`, 32: user word width.
- `ENCODER_DATA_IN_SIZE`, 8: character width per lane.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  400 MHz transmit clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `single_lane`  in  1  1 selects single-lane serialising mode, 0 selects all-lanes striping.
- `lane_select`  in  `MAX_LINKS_SIZE`  active lane in single-lane mode.
- `ordered_sets`  in  `ordered_sets_e`  requested ordered set; `NONE` means send data.
- `data_in`  in  `AXI_DATA_SIZE`  user word.
- `ctrl_out`  out  `[MAX_LINKS-1:0]`  per-lane K flag (1 means the character is a K-code).
- `data_out`  out  `[MAX_LINKS-1:0][ENCODER_DATA_IN_SIZE-1:0]`  per-lane character.

## Operation
- **Ordered-set encodings** (ctrl=1 for all of these):
  - `IDLE` = K28.5, 0xBC
  - `CLOCK_COMP` = K28.7, 0xFC
  - `CHANNEL_BOND` = K28.3, 0x7C
  - `RESYNC` = K28.0, 0x1C
- **Striping mode** (`single_lane`=0):
  - Ordered set ≠ `NONE`: the same K-code goes on every lane.
  - `NONE`: lane i gets `data_in[31-8i -: 8]` with ctrl=0. Lane 0 carries the MSB byte.
- **Single-lane mode** (`single_lane`=1):
  - A 2-bit byte counter `cnt` serialises one word over 4 cycles on lane `lane_select`, MSB byte first.
  - When `cnt`=0 and `ordered_sets`=`NONE`: latch `data_in`, emit byte [31:24], then `cnt`←1.
  - At `cnt`=1, 2, 3: emit bytes [23:16], [15:8], [7:0] in turn. `cnt` increments and wraps 3→0.
  - `data_in` is ignored while `cnt`≠0.
  - Ordered set ≠ `NONE` in any cycle: the K-code goes on the selected lane that cycle and `cnt` holds. The paused byte is sent on the next `NONE` cycle, so no data is lost.
  - Non-selected lanes always carry `IDLE` (0xBC, ctrl=1).
- **Mode and lane changes:**
  - `single_lane` and `lane_select` are sampled only when `cnt`=0. A change mid-word takes effect after the current word completes.
  - Leaving single-lane mode at a word boundary keeps `cnt`=0.
  - `lane_select` ≥ `MAX_LINKS` maps to lane 0.

## Timing
- All outputs are registered. Latency is 1 clk from input sampling to output.
- Reset value on every lane: `data_out`=0xBC, `ctrl_out`=1. Reset also clears `cnt`=0, the stored word, and the latched mode/lane.
- Reset asserted mid-word aborts the word. The first post-reset word starts at `cnt`=0.
- Single-lane throughput is one word per 4 clk with no ordered sets. Each ordered-set cycle inserted adds one cycle.
- No handshake. Upstream holds `data_in` valid at the edge where `cnt`=0 (e.g. a 100 MHz word domain, phase-aligned).

## Structure
- `aurora_pkg` holds:
  - the constants `MAX_LINKS`, `MAX_LINKS_SIZE`, `AXI_DATA_SIZE`, `ENCODER_DATA_IN_SIZE`;
  - `ordered_sets_e` (`NONE`, `IDLE`, `CLOCK_COMP`, `CHANNEL_BOND`, `RESYNC`);
  - the K-code constants and a function mapping `ordered_sets_e` to {ctrl, char}.
- The single-lane serialiser is a natural sub-module, `lane_serializer`, containing `cnt`, the stored word and the latched lane. The top level muxes the striping path against the serialiser.

## Test plan
- **Reset:** assert `rst`, release → all lanes 0xBC/ctrl=1 while `ordered_sets`=`IDLE`.
- **Striping:** `single_lane`=0, `NONE`, `data_in`=0x11223344 → next cycle lanes 0..3 = 0x11, 0x22, 0x33, 0x44, ctrl=0000.
- **Single lane:** `single_lane`=1, `lane_select`=2, word 0xA1B2C3D4 → lane 2 shows 0xA1, 0xB2, 0xC3, 0xD4 on 4 consecutive cycles, ctrl=0. Lanes 0, 1, 3 show 0xBC/ctrl=1.
- **Ordered-set insertion:** `CLOCK_COMP` asserted for 1 cycle after byte 0xB2 → lane 2 shows 0xB2, 0xFC (ctrl=1), 0xC3, 0xD4.
- **Mid-word lane change:** change `lane_select` 2→0 while `cnt`=1 → current word finishes on lane 2; the next word appears on lane 0.
- **Reset mid-word:** assert `rst` at `cnt`=2 → all lanes 0xBC/ctrl=1. The next word starts with its MSB byte.
